// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit engine.
// Optional parity stage is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;
`else
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;
`endif

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Host-side bundle of the UART transmit engine: byte push strobe plus FIFO/line status.
// Shared by both builds (with or without UART_TX_PARITY_EN).
interface uart_tx_engine_if #(
    parameter int ADDR_EXP = 4
);

    logic [7:0]      tx_byte;
    logic            transmit;
    logic            tx_fifo_full;
    logic            tx_fifo_empty;
    logic [ADDR_EXP:0] tx_fifo_count;
    logic            overflow;
    logic            busy;
    logic            tx;

    modport master (
        output tx_byte,
        output transmit,
        input  tx_fifo_full,
        input  tx_fifo_empty,
        input  tx_fifo_count,
        input  overflow,
        input  busy,
        input  tx
    );

    modport slave (
        input  tx_byte,
        input  transmit,
        output tx_fifo_full,
        output tx_fifo_empty,
        output tx_fifo_count,
        output overflow,
        output busy,
        output tx
    );

endinterface

// File: rtl/uart_tx_sfifo.sv
// Byte FIFO feeding the serializer; owns storage, pointers, occupancy and the sticky overflow flag.
// Identical in both builds (UART_TX_PARITY_EN does not affect it).
module uart_tx_sfifo #(
    parameter int ADDR_EXP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [7:0]        wr_data,
    input  logic              pop,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_EXP:0] count,
    output logic              overflow
);

    localparam int CNT_W = ADDR_EXP + 1;
    localparam int DEPTH = 1 << ADDR_EXP;

    logic [7:0]          mem [DEPTH];
    logic [ADDR_EXP-1:0] wr_ptr;
    logic [ADDR_EXP-1:0] rd_ptr;
    logic [CNT_W-1:0]    count_next;
    logic                push_ok;
    logic                pop_ok;

    // A push while full still lands when the serializer frees a slot on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_EXP'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_EXP'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
            if (push && full && !pop_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: byte FIFO plus start/data/stop serializer, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_engine #(
    parameter int CLOCK_DIVIDE = 271,
    parameter int ADDR_EXP     = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_engine_if.slave    bus
);

    import uart_pkg::*;

    localparam logic [15:0] BAUD_LAST = 16'(CLOCK_DIVIDE - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t         state;
    logic [15:0]       baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic              tx_reg;
    logic              bit_end;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_overflow;
    logic [7:0]        fifo_data;
    logic [ADDR_EXP:0] fifo_count;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    uart_tx_sfifo #(
        .ADDR_EXP (ADDR_EXP)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.transmit),
        .wr_data  (bus.tx_byte),
        .pop      (fifo_pop),
        .rd_data  (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (fifo_overflow)
    );

    assign bit_end  = (baud_cnt == BAUD_LAST);
    // Pop from IDLE, or at the last stop cycle so the next start bit follows with no gap.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));

    assign bus.tx_fifo_full  = fifo_full;
    assign bus.tx_fifo_empty = fifo_empty;
    assign bus.tx_fifo_count = fifo_count;
    assign bus.overflow      = fifo_overflow;
    assign bus.busy          = (state != IDLE) || !fifo_empty;
    assign bus.tx            = tx_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_reg    <= STOP_BIT;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    tx_reg   <= STOP_BIT;
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        shift_reg <= fifo_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= even_parity(fifo_data);
`endif
                        tx_reg    <= START_BIT;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_reg   <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx_reg <= parity_bit;
                            state  <= PARITY;
`else
                            tx_reg <= STOP_BIT;
                            state  <= STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= shift_reg >> 1;
                            tx_reg    <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_reg   <= STOP_BIT;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (fifo_pop) begin
                            shift_reg <= fifo_data;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= even_parity(fifo_data);
`endif
                            tx_reg    <= START_BIT;
                            state     <= START;
                        end else begin
                            tx_reg <= STOP_BIT;
                            state  <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    tx_reg <= STOP_BIT;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed scenarios plus random pushes against a queue model.
// Build with UART_TX_PARITY_EN defined to exercise the 11-bit frame.
module tb_uart_tx_engine;

    localparam int CD        = 4;
    localparam int AE        = 2;
    localparam int DEPTH     = 1 << AE;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS     = 11;
`else
    localparam int NBITS     = 10;
`endif
    localparam int FRAME_CYC = NBITS * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_engine_if #(.ADDR_EXP(AE)) bus ();

    uart_tx_engine #(
        .CLOCK_DIVIDE (CD),
        .ADDR_EXP     (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: FIFO content as a queue, frame progress as a cycle phase.
    logic [7:0] model_q [$];
    logic [7:0] cur_byte;
    bit         in_frame  = 1'b0;
    int         phase     = 0;
    bit         start_due = 1'b0;
    bit         model_ovf = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit do_reset, input bit push, input logic [7:0] data);
        @(negedge clk);
        rst          = do_reset;
        bus.transmit = push;
        bus.tx_byte  = data;
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        while (bus.busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_within_bound", 32'(n < max_cycles), 32'd1);
    endtask

    // Expected line level for frame bit k of a frame carrying byte b.
    function automatic logic expected_line(input int k, input logic [7:0] b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Per-edge model update and comparison, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            model_q.delete();
            in_frame  = 1'b0;
            phase     = 0;
            start_due = 1'b0;
            model_ovf = 1'b0;
            checkOutput("rst_tx",       32'(bus.tx),            32'd1);
            checkOutput("rst_empty",    32'(bus.tx_fifo_empty), 32'd1);
            checkOutput("rst_full",     32'(bus.tx_fifo_full),  32'd0);
            checkOutput("rst_count",    32'(bus.tx_fifo_count), 32'd0);
            checkOutput("rst_overflow", 32'(bus.overflow),      32'd0);
            checkOutput("rst_busy",     32'(bus.busy),          32'd0);
        end else begin
            if (in_frame) begin
                phase++;
                if (phase == FRAME_CYC) in_frame = 1'b0;
            end
            if (!in_frame) begin
                checkOutput("line_idle_or_start", 32'(bus.tx), start_due ? 32'd0 : 32'd1);
                if (start_due) begin
                    cur_byte = model_q.pop_front();
                    in_frame = 1'b1;
                    phase    = 0;
                end
            end
            if (in_frame && (phase % CD) == CD / 2) begin
                checkOutput($sformatf("frame_bit%0d", phase / CD), 32'(bus.tx),
                            32'(expected_line(phase / CD, cur_byte)));
            end
            if (bus.transmit) begin
                if (model_q.size() < DEPTH) model_q.push_back(bus.tx_byte);
                else model_ovf = 1'b1;
            end
            checkOutput("count",    32'(bus.tx_fifo_count), 32'(model_q.size()));
            checkOutput("full",     32'(bus.tx_fifo_full),  32'(model_q.size() == DEPTH));
            checkOutput("empty",    32'(bus.tx_fifo_empty), 32'(model_q.size() == 0));
            checkOutput("overflow", 32'(bus.overflow),      32'(model_ovf));
            checkOutput("busy",     32'(bus.busy),          32'(in_frame || model_q.size() > 0));
            start_due = (model_q.size() > 0) && (!in_frame || phase == FRAME_CYC - 1);
        end
    end

    initial begin
        int n;
        int busy_len;
        bus.transmit = 1'b0;
        bus.tx_byte  = 8'h00;
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);

        // Single frame and push-to-start latency.
        applyStimulus(1'b0, 1'b1, 8'hA5);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("lat_one_edge", 32'(bus.tx), 32'd1);
        @(negedge clk);
        checkOutput("lat_two_edges", 32'(bus.tx), 32'd0);
        waitIdle(200);

        // Back-to-back frames with no idle gap.
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("b2b_start", 32'(bus.tx), 32'd0);
        busy_len = 0;
        while (bus.busy && busy_len < 500) begin
            @(negedge clk);
            busy_len++;
        end
        checkOutput("b2b_busy_len", 32'(busy_len), 32'(2 * FRAME_CYC));

        // Fill to full, then one dropped push.
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 8'(i * 8'h11));
        applyStimulus(1'b0, 1'b1, 8'h66);
        checkOutput("fill_count", 32'(bus.tx_fifo_count), 32'd4);
        checkOutput("fill_full",  32'(bus.tx_fifo_full),  32'd1);
        checkOutput("fill_no_ovf", 32'(bus.overflow),     32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("ovf_set",    32'(bus.overflow),      32'd1);
        checkOutput("ovf_count",  32'(bus.tx_fifo_count), 32'd4);
        waitIdle(600);

        // Push while full on the exact edge the serializer pops.
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 8'(i * 8'h11));
        applyStimulus(1'b0, 1'b0, 8'h00);
        n = 0;
        while (!(in_frame && start_due && model_q.size() == DEPTH) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pop_edge_found", 32'(n < 200), 32'd1);
        bus.transmit = 1'b1;
        bus.tx_byte  = 8'h77;
        @(negedge clk);
        bus.transmit = 1'b0;
        checkOutput("fullpop_count", 32'(bus.tx_fifo_count), 32'd4);
        checkOutput("fullpop_ovf",   32'(bus.overflow),      32'd0);
        waitIdle(800);

        // Reset in the middle of data bit 3, then a clean frame.
        applyStimulus(1'b0, 1'b1, 8'hC3);
        applyStimulus(1'b0, 1'b0, 8'h00);
        n = 0;
        while (!(in_frame && phase == 4 * CD + 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_bit3_found", 32'(n < 100), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_tx",    32'(bus.tx),            32'd1);
        checkOutput("midrst_empty", 32'(bus.tx_fifo_empty), 32'd1);
        checkOutput("midrst_busy",  32'(bus.busy),          32'd0);
        applyStimulus(1'b0, 1'b1, 8'h5A);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("post_rst_lat1", 32'(bus.tx), 32'd1);
        @(negedge clk);
        checkOutput("post_rst_lat2", 32'(bus.tx), 32'd0);
        waitIdle(200);

        // Parity polarity bytes (plain frames when parity is not built in).
        applyStimulus(1'b0, 1'b1, 8'h07);
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitIdle(200);
        applyStimulus(1'b0, 1'b1, 8'h03);
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitIdle(200);

        // Random pushes with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 99) < 30, 8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitIdle(1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter CLOCK_DIVIDE, default 271: clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter ADDR_EXP, default 4: FIFO depth is 2**ADDR_EXP entries of 8 bits; legal range 1..12.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port tx_byte, input, 8: byte to enqueue.
REQ-006 SHALL have port transmit, input, 1: one-cycle push strobe for tx_byte.
REQ-007 SHALL have port tx_fifo_full, output, 1: registered; FIFO holds 2**ADDR_EXP entries.
REQ-008 SHALL have port tx_fifo_empty, output, 1: registered; FIFO holds 0 entries.
REQ-009 SHALL have port tx_fifo_count, output, ADDR_EXP+1: registered occupancy.
REQ-010 SHALL have port overflow, output, 1: sticky; set by a push while full.
REQ-011 SHALL have port busy, output, 1: high while the serializer is not IDLE or the FIFO is non-empty.
REQ-012 SHALL have port tx, output, 1: registered serial line, idle high, LSB first.

Function
REQ-013 Push: transmit=1 with tx_fifo_full=0 SHALL write tx_byte at the write pointer at that edge; count increments by 1.
REQ-014 Push with tx_fifo_full=1 and no same-cycle pop SHALL be dropped, set overflow, and leave count and contents unchanged.
REQ-015 Simultaneous push and pop SHALL both complete and leave count unchanged, including when full (the push is accepted) and when count=1.
REQ-016 Pointers SHALL be ADDR_EXP bits and wrap from 2**ADDR_EXP-1 to 0 without gap.
REQ-017 Serializer FSM states SHALL be IDLE, START, DATA, STOP, plus PARITY when enabled (REQ-026).
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop the head byte into an 8-bit shift register and enter START on the same edge.
REQ-019 START SHALL drive tx=0 for CLOCK_DIVIDE cycles.
REQ-020 DATA SHALL drive bits 0..7 in order, each for CLOCK_DIVIDE cycles, using a 3-bit bit index.
REQ-021 STOP SHALL drive tx=1 for CLOCK_DIVIDE cycles.
REQ-022 At the end of STOP, the FSM SHALL pop the next byte and go directly to START if the FIFO is non-empty, otherwise go to IDLE; there are no idle cycles between back-to-back frames.
REQ-023 The baud counter SHALL count 0..CLOCK_DIVIDE-1 and reload to 0 on each bit boundary.
REQ-024 Latency: after a push into an empty FIFO with the FSM in IDLE at edge N, tx SHALL be 0 from edge N+2.

Reset
REQ-025 While rst=1 at an edge, regardless of any frame in progress, the block SHALL:
- set tx=1, state=IDLE, pointers=0, count=0, tx_fifo_empty=1, tx_fifo_full=0, overflow=0, busy=0;
- abort any frame in progress;
- leave FIFO storage contents uninitialised.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined:
- a PARITY state SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) for CLOCK_DIVIDE cycles;
- a frame is 11 bits.
Without the macro, there SHALL be no PARITY state and a frame is 10 bits.

Structure
REQ-027 A shared package uart_pkg SHALL hold:
- the FSM state enumeration;
- the frame-bit constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8).
REQ-028 The FIFO SHALL be one sub-module, uart_tx_sfifo, parameterised by ADDR_EXP. It owns the storage, pointers, count, full, empty and overflow.
REQ-029 The serializer FSM SHALL reside in uart_tx_engine.

Verification (CLOCK_DIVIDE=4, ADDR_EXP=2)
REQ-030 Single frame: push 0xA5 at edge N:
- tx low for edges N+2..N+5;
- then data bits 1,0,1,0,0,1,0,1, 4 cycles each;
- then high for 4 cycles;
- busy falls at the cycle after STOP ends.
REQ-031 Back-to-back: push 0x00 then 0xFF on consecutive cycles. tx SHALL carry two frames with no idle gap; total busy duration SHALL be 80 cycles (88 with parity).
REQ-032 Full/overflow:
- 5 pushes (0x11..0x55) while the first frame transmits → tx_fifo_full=1 and count=4 after the 5th push;
- a 6th push → overflow=1, and 0x66 never appears on tx.
REQ-033 Full with pop: push on the exact cycle the FSM pops at the end of STOP while full → push accepted, count stays 4, overflow stays 0.
REQ-034 Reset mid-frame: assert rst during DATA bit 3 → next edge tx=1, empty=1, busy=0. A push after release SHALL produce a clean frame with latency 2.
REQ-035 Parity build (UART_TX_PARITY_EN): push 0x07 → parity bit 1 between bit 7 and STOP. Push 0x03 → parity bit 0.
